// File: rtl/cpu_top.sv
// rtl/cpu_top.sv - four-stage (IF/ID/EX/WB) pipelined 16-bit core with instruction ROM, register file and data RAM
module cpu_top #(
    parameter string IMEM_FILE  = "program.hex",
    parameter int    IMEM_DEPTH = 256,
    parameter int    DMEM_BYTES = 256
) (
    input logic clk,
    input logic rst
);

    localparam logic [4:0] OP_HALT = 5'b10000;
    localparam logic [4:0] OP_BEQ  = 5'b01100;
    localparam logic [4:0] OP_BNEQ = 5'b01101;
    localparam logic [4:0] OP_JMP  = 5'b01110;
    localparam logic [4:0] OP_LDST = 5'b11111;

    typedef enum logic {S_RUN, S_HALT} run_state_t;

    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [7:0]  dmem [0:DMEM_BYTES-1];
    logic [15:0] rf   [0:15];

    run_state_t  state, state_next;
    logic        halted;
    logic [7:0]  pc;
    logic [31:0] id_ir, ex_ir, wb_ir;
    logic [15:0] ex_a, ex_b, ex_c;
    logic [15:0] wb_res, wb_sd;
    logic        carry, neg;

    function automatic logic writes_rd(input logic [4:0] op, input logic is_load);
        logic w;
        w = 1'b0;
        case (op)
            5'b00001, 5'b10001, 5'b00010, 5'b10010, 5'b00011, 5'b10011,
            5'b00100, 5'b10100, 5'b00101, 5'b10101, 5'b00110, 5'b10110,
            5'b00111, 5'b10111, 5'b01000, 5'b11000, 5'b01001, 5'b01010,
            5'b11010, 5'b01011, 5'b11011: w = 1'b1;
            OP_LDST:                      w = is_load;
            default:                      w = 1'b0;
        endcase
        return w;
    endfunction

    // Write-back stage: async RAM read, result mux, register write enable
    logic        wb_we, wb_is_ldst;
    logic [3:0]  wb_rd;
    logic [7:0]  wb_addr, wb_waddr;
    logic [15:0] wb_load, wb_data;

    assign halted     = (state == S_HALT);
    assign wb_rd      = wb_ir[19:16];
    assign wb_is_ldst = (wb_ir[26:22] == OP_LDST);
    assign wb_we      = writes_rd(wb_ir[26:22], ~wb_ir[20]) && (wb_rd != 4'd0);
    assign wb_addr    = wb_res[7:0];
    assign wb_waddr   = {wb_res[7:1], 1'b0};
    assign wb_load    = wb_ir[21] ? {dmem[{wb_waddr[7:1], 1'b1}], dmem[wb_waddr]}
                                  : {8'd0, dmem[wb_addr]};
    assign wb_data    = wb_is_ldst ? wb_load : wb_res;

    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_ir[31:27], wb_ir[15:0]};

    // Decode-stage register reads see the same-cycle write-back
    logic [15:0] id_r1, id_r2, id_rd;
    logic        id_halt;

    always_comb begin
        id_r1 = rf[id_ir[15:12]];
        id_r2 = rf[id_ir[11:8]];
        id_rd = rf[id_ir[19:16]];
        if (wb_we && wb_rd == id_ir[15:12]) id_r1 = wb_data;
        if (wb_we && wb_rd == id_ir[11:8])  id_r2 = wb_data;
        if (wb_we && wb_rd == id_ir[19:16]) id_rd = wb_data;
        if (id_ir[15:12] == 4'd0) id_r1 = '0;
        if (id_ir[11:8]  == 4'd0) id_r2 = '0;
        if (id_ir[19:16] == 4'd0) id_rd = '0;
    end

    assign id_halt = (id_ir[26:22] == OP_HALT);

    // Execute stage: WB bypass, ALU, branch resolution
    logic [4:0]  ex_op;
    logic [15:0] ex_imm, op_a, op_b, op_c, src2, alu_res;
    logic [16:0] sum17;
    logic        ex_taken;

    assign ex_op  = ex_ir[26:22];
    assign ex_imm = {{4{ex_ir[11]}}, ex_ir[11:0]};
    assign op_a   = (wb_we && wb_rd == ex_ir[15:12]) ? wb_data : ex_a;
    assign op_b   = (wb_we && wb_rd == ex_ir[11:8])  ? wb_data : ex_b;
    assign op_c   = (wb_we && wb_rd == ex_ir[19:16]) ? wb_data : ex_c;
    assign src2   = ex_op[4] ? ex_imm : op_b;
    assign sum17  = {1'b0, op_a} + {1'b0, src2};

    always_comb begin
        alu_res = '0;
        case (ex_op[3:0])
            4'h1:    alu_res = sum17[15:0];
            4'h2:    alu_res = op_a - src2;
            4'h3:    alu_res = $unsigned($signed(op_a) >>> src2[3:0]);
            4'h4:    alu_res = op_a << src2[3:0];
            4'h5:    alu_res = op_a >> src2[3:0];
            4'h6:    alu_res = op_a & src2;
            4'h7:    alu_res = op_a | src2;
            4'h8:    alu_res = {15'd0, ($signed(op_a) < $signed(src2))};
            4'h9:    alu_res = ~op_a;
            4'hA:    alu_res = src2;
            4'hB:    alu_res = 16'($countones(op_a ^ src2));
            4'hF:    alu_res = sum17[15:0];
            default: alu_res = '0;
        endcase
    end

    assign ex_taken = ((ex_op == OP_BEQ)  && (op_a == op_b)) ||
                      ((ex_op == OP_BNEQ) && (op_a != op_b)) ||
                       (ex_op == OP_JMP);

    always_comb begin
        state_next = state;
        if (state == S_RUN && !ex_taken && id_halt) state_next = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            id_ir  <= '0;
            ex_ir  <= '0;
            wb_ir  <= '0;
            ex_a   <= '0;
            ex_b   <= '0;
            ex_c   <= '0;
            wb_res <= '0;
            wb_sd  <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
        end else begin
            wb_ir  <= ex_ir;
            wb_res <= alu_res;
            wb_sd  <= op_c;
            if (ex_op[3:0] == 4'h1) carry <= sum17[16];
            if (ex_op[3:0] == 4'h2) neg   <= alu_res[15];
            if (ex_taken) begin
                // Squash the two younger instructions and redirect fetch
                pc    <= ex_ir[7:0];
                id_ir <= '0;
                ex_ir <= '0;
            end else begin
                ex_ir <= id_ir;
                ex_a  <= id_r1;
                ex_b  <= id_r2;
                ex_c  <= id_rd;
                if (halted || id_halt) begin
                    id_ir <= '0;
                end else begin
                    id_ir <= imem[pc];
                    pc    <= pc + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Data RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (!rst && wb_is_ldst && wb_ir[20]) begin
            if (wb_ir[21]) begin
                dmem[wb_waddr]                 <= wb_sd[7:0];
                dmem[{wb_waddr[7:1], 1'b1}]    <= wb_sd[15:8];
            end else begin
                dmem[wb_addr]                  <= wb_sd[7:0];
            end
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
// tb/tb_cpu_top.sv - directed and random programs checked against an instruction-level model
module tb_cpu_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_top #(.IMEM_FILE(""), .IMEM_DEPTH(256), .DMEM_BYTES(256)) dut (.clk(clk), .rst(rst));

    localparam logic [4:0] O_HALT = 5'b10000, O_ADD = 5'b00001, O_ADDI = 5'b10001;
    localparam logic [4:0] O_SUB = 5'b00010, O_ASRI = 5'b10011, O_LSLI = 5'b10100;
    localparam logic [4:0] O_LSRI = 5'b10101, O_ORI = 5'b10111, O_SLTI = 5'b11000;
    localparam logic [4:0] O_MOVI = 5'b11010, O_HDI = 5'b11011, O_BEQ = 5'b01100;
    localparam logic [4:0] O_BNEQ = 5'b01101, O_JMP = 5'b01110, O_LDST = 5'b11111;

    int tests = 0;
    int fails = 0;
    logic [31:0] prog [256];
    int init_mem [256];
    int m_reg [16];
    int m_mem [256];
    int m_carry, m_neg;

    logic [4:0] alu_ops [21] = '{5'b00001, 5'b10001, 5'b00010, 5'b10010, 5'b00011, 5'b10011,
                                 5'b00100, 5'b10100, 5'b00101, 5'b10101, 5'b00110, 5'b10110,
                                 5'b00111, 5'b10111, 5'b01000, 5'b11000, 5'b01001, 5'b01010,
                                 5'b11010, 5'b01011, 5'b11011};
    logic [4:0] nop_ops [6] = '{5'b00000, 5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b01111};
    logic [4:0] br_ops [3]  = '{O_BEQ, O_BNEQ, O_JMP};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fi(input logic [4:0] op, input int rd, input int rs1, input int imm);
        return {5'd0, op, 2'd0, 4'(rd), 4'(rs1), 12'(imm)};
    endfunction
    function automatic logic [31:0] fr(input logic [4:0] op, input int rd, input int rs1, input int rs2);
        return {5'd0, op, 2'd0, 4'(rd), 4'(rs1), 4'(rs2), 8'd0};
    endfunction
    function automatic logic [31:0] fb(input logic [4:0] op, input int rs1, input int rs2, input int lab);
        return {5'd0, op, 2'd0, 4'd0, 4'(rs1), 4'(rs2), 8'(lab)};
    endfunction
    function automatic logic [31:0] fls(input int sub, input int rd, input int rs1, input int imm);
        return {5'd0, O_LDST, 2'(sub), 4'(rd), 4'(rs1), 12'(imm)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            prog[i] = '0;
            init_mem[i] = $urandom_range(0, 255);
        end
    endtask

    // Load ROM/RAM while held in reset; returns just after reset is released
    task automatic start();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut.imem[i] = prog[i];
            dut.dmem[i] = 8'(init_mem[i]);
        end
        tick(2);
        rst = 1'b0;
    endtask

    function automatic int sx16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Sequential instruction-set model: one instruction at a time, no pipeline
    task automatic run_model();
        int pc, a, b, imm, res, addr;
        logic [31:0] w;
        logic [4:0] op;
        pc = 0; m_carry = 0; m_neg = 0;
        for (int r = 0; r < 16; r++) m_reg[r] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = init_mem[i];
        for (int step = 0; step < 2000; step++) begin
            w = prog[pc];
            op = w[26:22];
            if (op == O_HALT) break;
            imm = w[11] ? int'(w[11:0]) - 4096 : int'(w[11:0]);
            a = m_reg[w[15:12]];
            b = op[4] ? (imm & 65535) : m_reg[w[11:8]];
            res = -1;
            pc = (pc + 1) % 256;
            case (op)
                5'b00001, 5'b10001: begin res = (a + b) % 65536; m_carry = (a + b) / 65536; end
                5'b00010, 5'b10010: begin res = (a - b) & 65535; m_neg = res / 32768; end
                5'b00011, 5'b10011: res = (sx16(a) >>> (b % 16)) & 65535;
                5'b00100, 5'b10100: res = (a << (b % 16)) & 65535;
                5'b00101, 5'b10101: res = a >> (b % 16);
                5'b00110, 5'b10110: res = a & b;
                5'b00111, 5'b10111: res = a | b;
                5'b01000, 5'b11000: res = (sx16(a) < sx16(b)) ? 1 : 0;
                5'b01001:           res = (~a) & 65535;
                5'b01010, 5'b11010: res = b;
                5'b01011, 5'b11011: begin
                    res = 0;
                    for (int k = 0; k < 16; k++) res += ((a ^ b) >> k) & 1;
                end
                O_BEQ:  if (a == m_reg[w[11:8]]) pc = w[7:0];
                O_BNEQ: if (a != m_reg[w[11:8]]) pc = w[7:0];
                O_JMP:  pc = w[7:0];
                O_LDST: begin
                    addr = (a + imm) & 255;
                    case (w[21:20])
                        2'd0: res = m_mem[addr];
                        2'd1: m_mem[addr] = m_reg[w[19:16]] & 255;
                        2'd2: begin addr = addr & 254; res = m_mem[addr] + 256 * m_mem[addr + 1]; end
                        default: begin
                            addr = addr & 254;
                            m_mem[addr] = m_reg[w[19:16]] & 255;
                            m_mem[addr + 1] = m_reg[w[19:16]] / 256;
                        end
                    endcase
                end
                default: ;
            endcase
            if (res >= 0 && w[19:16] != 4'd0) m_reg[w[19:16]] = res;
        end
    endtask

    task automatic wait_halt(input string tag);
        int cyc;
        cyc = 0;
        while (dut.halted !== 1'b1 && cyc < 1000) begin
            tick(1);
            cyc++;
        end
        chk({tag, "_halt_reached"}, 32'(dut.halted), 32'd1);
        tick(3);
    endtask

    task automatic compare_model(input string tag);
        int nbad;
        run_model();
        for (int r = 1; r < 16; r++)
            chk($sformatf("%s_R%0d", tag, r), 32'(dut.rf[r]), 32'(m_reg[r]));
        chk({tag, "_carry"}, 32'(dut.carry), 32'(m_carry));
        chk({tag, "_neg"}, 32'(dut.neg), 32'(m_neg));
        nbad = 0;
        for (int i = 0; i < 256; i++) if (dut.dmem[i] !== 8'(m_mem[i])) nbad++;
        chk({tag, "_dmem_bad_bytes"}, 32'(nbad), 32'd0);
    endtask

    initial begin
        int n, rsel, len;
        logic [4:0] op;

        // ALU chain with forwarding, plus reset state and write-back latency
        clear_prog();
        prog[0] = fi(O_MOVI, 1, 0, 5);
        prog[1] = fi(O_MOVI, 2, 0, 7);
        prog[2] = fr(O_ADD, 3, 1, 2);
        prog[3] = fr(O_SUB, 4, 1, 2);
        prog[4] = fi(O_HALT, 0, 0, 0);
        start();
        chk("rst_pc", 32'(dut.pc), 0);
        chk("rst_id", dut.id_ir, 0);
        chk("rst_ex", dut.ex_ir, 0);
        chk("rst_wb", dut.wb_ir, 0);
        chk("rst_carry_neg", {30'd0, dut.carry, dut.neg}, 0);
        tick(1);
        chk("if_pc", 32'(dut.pc), 1);
        chk("if_id", dut.id_ir, prog[0]);
        tick(2);
        chk("wb_ir_movi", dut.wb_ir, prog[0]);
        chk("r1_before_wb", 32'(dut.rf[1]), 0);
        tick(1);
        chk("r1_after_wb", 32'(dut.rf[1]), 5);
        wait_halt("alu");
        chk("alu_R3", 32'(dut.rf[3]), 12);
        chk("alu_R4", 32'(dut.rf[4]), 32'hFFFE);
        chk("alu_carry", 32'(dut.carry), 0);
        chk("alu_neg", 32'(dut.neg), 1);
        compare_model("alu");

        // Carry, compare, Hamming distance and shifts on all-ones
        clear_prog();
        prog[0] = fi(O_MOVI, 1, 0, 12'hFFF);
        prog[1] = fi(O_ADDI, 2, 1, 1);
        prog[2] = fi(O_SLTI, 3, 1, 0);
        prog[3] = fi(O_HDI, 4, 1, 0);
        prog[4] = fi(O_ASRI, 5, 1, 4);
        prog[5] = fi(O_LSRI, 6, 1, 12);
        prog[6] = fi(O_HALT, 0, 0, 0);
        start();
        wait_halt("flags");
        chk("flags_R2", 32'(dut.rf[2]), 0);
        chk("flags_carry", 32'(dut.carry), 1);
        chk("flags_R3", 32'(dut.rf[3]), 1);
        chk("flags_R4", 32'(dut.rf[4]), 16);
        chk("flags_R5", 32'(dut.rf[5]), 32'hFFFF);
        chk("flags_R6", 32'(dut.rf[6]), 32'h000F);
        compare_model("flags");

        // Little-endian word store followed immediately by byte and word loads
        clear_prog();
        prog[0] = fi(O_MOVI, 1, 0, 12'h123);
        prog[1] = fi(O_LSLI, 1, 1, 4);
        prog[2] = fi(O_ORI, 1, 1, 4);
        prog[3] = fls(3, 1, 0, 4);
        prog[4] = fls(0, 2, 0, 5);
        prog[5] = fls(2, 3, 0, 4);
        prog[6] = fi(O_HALT, 0, 0, 0);
        start();
        wait_halt("mem");
        chk("mem_R2", 32'(dut.rf[2]), 32'h0012);
        chk("mem_R3", 32'(dut.rf[3]), 32'h1234);
        compare_model("mem");

        // Taken branch squashes two slots; untaken branch costs nothing
        clear_prog();
        prog[0]  = fi(O_MOVI, 1, 0, 1);
        prog[1]  = fi(O_MOVI, 2, 0, 2);
        prog[3]  = fb(O_BEQ, 0, 0, 10);
        prog[4]  = fi(O_MOVI, 5, 0, 5);
        prog[5]  = fi(O_MOVI, 6, 0, 6);
        prog[10] = fi(O_MOVI, 8, 0, 8);
        prog[11] = fb(O_BNEQ, 1, 1, 20);
        prog[12] = fi(O_MOVI, 9, 0, 9);
        prog[13] = fi(O_HALT, 0, 0, 0);
        prog[20] = fi(O_MOVI, 10, 0, 10);
        start();
        tick(6);
        chk("br_pc", 32'(dut.pc), 10);
        chk("br_id_squash", dut.id_ir, 0);
        chk("br_ex_squash", dut.ex_ir, 0);
        chk("br_wb_label", 32'(dut.wb_ir[7:0]), 10);
        tick(1);
        chk("br_target_fetch", dut.id_ir, prog[10]);
        tick(3);
        chk("bneq_pc", 32'(dut.pc), 14);
        chk("bneq_no_bubble", dut.ex_ir, prog[12]);
        wait_halt("br");
        chk("br_R5", 32'(dut.rf[5]), 0);
        chk("br_R9", 32'(dut.rf[9]), 9);
        compare_model("br");

        // HALT at address 6 freezes PC at 7 until reset
        clear_prog();
        for (int i = 0; i < 6; i++) prog[i] = fi(O_MOVI, i + 1, 0, 11 * (i + 1));
        prog[6] = fi(O_HALT, 0, 0, 0);
        prog[7] = fi(O_MOVI, 7, 0, 7);
        prog[8] = fi(O_MOVI, 8, 0, 8);
        start();
        tick(7);
        chk("halt_pc7", 32'(dut.pc), 7);
        chk("halt_in_id", dut.id_ir, prog[6]);
        tick(1);
        chk("halt_id_nop", dut.id_ir, 0);
        tick(50);
        chk("halt_pc_frozen", 32'(dut.pc), 7);
        compare_model("halt");
        rst = 1'b1;
        tick(1);
        chk("halt_rst_pc", 32'(dut.pc), 0);
        rst = 1'b0;
        tick(1);
        chk("halt_restart_pc", 32'(dut.pc), 1);
        chk("halt_restart_id", dut.id_ir, prog[0]);

        // Reset in the middle of a run
        clear_prog();
        for (int i = 0; i < 15; i++) prog[i] = fi(O_MOVI, i + 1, 0, 100 + i);
        prog[15] = fi(O_ADDI, 1, 1, 12'h7FF);
        prog[16] = fr(O_SUB, 2, 0, 1);
        start();
        tick(20);
        chk("midrun_R1_set", 32'(dut.rf[1] != 0), 1);
        rst = 1'b1;
        tick(1);
        chk("midrun_pc", 32'(dut.pc), 0);
        chk("midrun_pipe", {dut.id_ir | dut.ex_ir | dut.wb_ir}, 0);
        n = 0;
        for (int r = 0; r < 16; r++) if (dut.rf[r] !== 16'd0) n++;
        chk("midrun_rf_nonzero", 32'(n), 0);
        chk("midrun_flags", {30'd0, dut.carry, dut.neg}, 0);

        // Random programs with forward-only branches, ended by HALT
        for (int t = 0; t < 12; t++) begin
            clear_prog();
            len = 30;
            for (int i = 0; i < len; i++) begin
                rsel = $urandom_range(0, 99);
                prog[i] = $urandom;
                if (rsel < 55)      op = alu_ops[$urandom_range(0, 20)];
                else if (rsel < 80) op = O_LDST;
                else if (rsel < 90) begin
                    op = br_ops[$urandom_range(0, 2)];
                    prog[i][7:0] = 8'($urandom_range(i + 1, len));
                end else            op = nop_ops[$urandom_range(0, 5)];
                prog[i][26:22] = op;
            end
            prog[len] = $urandom;
            prog[len][26:22] = O_HALT;
            start();
            wait_halt($sformatf("rnd%0d", t));
            compare_model($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
